// File: rtl/iram_bank_loader_if.sv
// Bus bundle for iram_bank_loader.
// Carries the per-core read ports and the shared program-loader port.
//   slave  : seen by the IRAM bank (reads requests, drives data/status)
//   master : seen by the fetch stages and the program loader
// Read port    : rd_en, rd_addr -> rd_data, rd_valid
// Loader port  : ld_start, ld_mode, ld_core, ld_base, ld_len, ld_valid, ld_data
//                -> ld_ready, ld_busy, ld_done, ld_err
// Fetch stall  : core_hold
interface iram_bank_loader_if #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int CORE_W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]             rd_en;
  logic [N-1:0][ADDR_W-1:0] rd_addr;
  logic [N-1:0][DATA_W-1:0] rd_data;
  logic [N-1:0]             rd_valid;

  logic                     ld_start;
  logic                     ld_mode;
  logic [CORE_W-1:0]        ld_core;
  logic [ADDR_W-1:0]        ld_base;
  logic [ADDR_W:0]          ld_len;
  logic                     ld_valid;
  logic [DATA_W-1:0]        ld_data;
  logic                     ld_ready;
  logic                     ld_busy;
  logic                     ld_done;
  logic                     ld_err;
  logic [N-1:0]             core_hold;

  modport master (
    output rd_en, rd_addr, ld_start, ld_mode, ld_core, ld_base, ld_len,
           ld_valid, ld_data,
    input  rd_data, rd_valid, ld_ready, ld_busy, ld_done, ld_err, core_hold
  );

  modport slave (
    input  rd_en, rd_addr, ld_start, ld_mode, ld_core, ld_base, ld_len,
           ld_valid, ld_data,
    output rd_data, rd_valid, ld_ready, ld_busy, ld_done, ld_err, core_hold
  );
endinterface

// File: rtl/iram_bank_loader.sv
// N-core instruction-memory bank: one private IRAM per core, each with a
// registered 1-cycle read port, plus a shared loader that streams words into
// one core's IRAM or broadcasts them to all. Cores being loaded are stalled
// through core_hold, which also blocks their reads so a read never meets a
// write on the same array.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (storage is not cleared)
//   bus  : iram_bank_loader_if.slave (read ports, loader port, core_hold)
module iram_bank_loader #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  iram_bank_loader_if.slave bus
);
  localparam int CORE_W = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state, state_next;
  logic                mode_q;
  logic                err_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     count_q;
  logic [N-1:0]        mask_q;     // cores written and held by the current load

  logic                start_err;
  logic [N-1:0]        start_mask;
  logic                beat;
  logic [ADDR_W-1:0]   wr_addr;
  logic [N-1:0]        wr_en;

  logic [DATA_W-1:0]   mem [N][DEPTH];

  // Target set of a new load: every core for broadcast, the selected core in
  // single mode, nobody when the selected core does not exist.
  always_comb begin
    start_err  = bus.ld_mode && (32'(bus.ld_core) >= 32'(N));
    start_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (!bus.ld_mode)
        start_mask[i] = 1'b1;
      else if (bus.ld_core == CORE_W'(i))
        start_mask[i] = !start_err;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    bus.ld_ready  = (state == LOAD);
    bus.ld_busy   = (state != IDLE);
    bus.ld_done   = (state == DONE);
    bus.ld_err    = (state == DONE) && err_q;
    bus.core_hold = (state != IDLE) ? mask_q : '0;
    beat          = (state == LOAD) && bus.ld_valid;
    case (state)
      IDLE: if (bus.ld_start) state_next = (bus.ld_len == '0) ? DONE : LOAD;
      LOAD: if (beat && (count_q + ONE == len_q)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write address wraps naturally at the ADDR_W boundary.
  assign wr_addr = base_q + count_q[ADDR_W-1:0];
  assign wr_en   = {N{beat}} & mask_q;

  // NOTE: state and counters use non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.ld_start) begin
        mode_q  <= bus.ld_mode;
        err_q   <= start_err;
        base_q  <= bus.ld_base;
        len_q   <= bus.ld_len;
        count_q <= '0;
        mask_q  <= start_mask;
      end else if (beat) begin
        count_q <= count_q + ONE;
      end
    end
  end

  // NOTE: the arrays have no reset; clearing them would need one write per
  // word, and their content is only meaningful once loaded.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (wr_en[i]) mem[i][wr_addr] <= bus.ld_data;
  end

  // Independent read ports; a held core keeps its last data.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        bus.rd_valid[i] <= bus.rd_en[i] && !bus.core_hold[i];
        if (bus.rd_en[i] && !bus.core_hold[i])
          bus.rd_data[i] <= mem[i][bus.rd_addr[i]];
      end
    end
  end

  logic unused_mode;
  assign unused_mode = mode_q;
endmodule

// File: tb/tb_iram_bank_loader.sv
// Self-checking bench for iram_bank_loader: a 4-core instance exercised by a
// table of load descriptors with a read scoreboard running alongside, plus
// hand-written sequences for reset mid-load and (on a 3-core instance) an
// invalid target core.
module tb_iram_bank_loader;
  localparam int N     = 4;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iram_bank_loader_if #(.N(4), .DATA_W(16), .ADDR_W(9)) bus ();
  iram_bank_loader #(.N(4), .DATA_W(16), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  iram_bank_loader_if #(.N(3), .DATA_W(16), .ADDR_W(9)) bus3 ();
  iram_bank_loader #(.N(3), .DATA_W(16), .ADDR_W(9)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference memory and expected hold state for the 4-core instance.
  logic [15:0] model [N][DEPTH];
  logic [3:0]  exp_hold;
  logic [3:0]  rd_mask_tb;
  logic [3:0]  rd_rand;
  logic [8:0]  rd_addr_tb [N];
  logic [15:0] last_exp [N];

  typedef struct {
    int         core;
    logic       valid;
    logic [15:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];

  // Read scoreboard: at #2 after each edge drive reads and push what they must
  // return; at #1 after the next edge pop and compare.
  initial begin : reader
    rd_exp_t e;
    logic [8:0] a;
    for (int i = 0; i < N; i++) last_exp[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("rd_valid[%0d]", e.core), 32'(bus.rd_valid[e.core]), 32'(e.valid));
        if (!$isunknown(e.data))
          check($sformatf("rd_data[%0d]", e.core), 32'(bus.rd_data[e.core]), 32'(e.data));
      end
      #1;
      for (int i = 0; i < N; i++) begin
        a = rd_rand[i] ? 9'($urandom_range(DEPTH - 1, 0)) : rd_addr_tb[i];
        bus.rd_en[i]   = rd_mask_tb[i];
        bus.rd_addr[i] = a;
        if (rst) begin
          last_exp[i] = '0;
          e = '{i, 1'b0, 16'h0};
        end else if (rd_mask_tb[i] && !exp_hold[i]) begin
          last_exp[i] = model[i][a];
          e = '{i, 1'b1, model[i][a]};
        end else begin
          e = '{i, 1'b0, last_exp[i]};
        end
        sb.push_back(e);
      end
    end
  end

  typedef struct {
    string       name;
    logic        mode;
    int          core;
    int          base;
    int          len;
    logic [15:0] d0;
    int          gap_at;
    int          gap_len;
    bit          poke;
    logic [3:0]  exp_hold;
    logic        exp_err;
  } load_vec_t;

  task automatic run_load(input load_vec_t v);
    bus.ld_mode  = v.mode;
    bus.ld_core  = 2'(v.core);
    bus.ld_base  = 9'(v.base);
    bus.ld_len   = 10'(v.len);
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    exp_hold = v.exp_hold;
    check({v.name, ".hold"}, 32'(bus.core_hold), 32'(v.exp_hold));
    check({v.name, ".busy"}, 32'(bus.ld_busy), 1);
    if (v.len == 0) begin
      check({v.name, ".done"}, 32'(bus.ld_done), 1);
      check({v.name, ".ready"}, 32'(bus.ld_ready), 0);
      check({v.name, ".err"}, 32'(bus.ld_err), 32'(v.exp_err));
      tick();
      exp_hold = '0;
      check({v.name, ".done_end"}, 32'(bus.ld_done), 0);
      check({v.name, ".ready_end"}, 32'(bus.ld_ready), 0);
    end else begin
      check({v.name, ".ready"}, 32'(bus.ld_ready), 1);
      check({v.name, ".done_early"}, 32'(bus.ld_done), 0);
      for (int i = 0; i < v.len; i++) begin
        if (i == v.gap_at) begin
          for (int g = 0; g < v.gap_len; g++) begin
            bus.ld_valid = 1'b0;
            tick();
            check({v.name, ".gap_ready"}, 32'(bus.ld_ready), 1);
            check({v.name, ".gap_done"}, 32'(bus.ld_done), 0);
          end
        end
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'(v.d0 + i);
        if (v.poke && i == 1) begin
          bus.ld_start = 1'b1;
          bus.ld_mode  = 1'b1;
          bus.ld_core  = 2'd0;
          bus.ld_base  = 9'd0;
          bus.ld_len   = 10'd1;
        end
        for (int c = 0; c < N; c++)
          if (!v.mode || c == v.core) model[c][(v.base + i) % DEPTH] = 16'(v.d0 + i);
        tick();
        bus.ld_start = 1'b0;
        if (i < v.len - 1) begin
          if (i == 0 || i == v.len - 2) check({v.name, ".mid_done"}, 32'(bus.ld_done), 0);
        end else begin
          check({v.name, ".done"}, 32'(bus.ld_done), 1);
          check({v.name, ".err"}, 32'(bus.ld_err), 32'(v.exp_err));
          check({v.name, ".done_ready"}, 32'(bus.ld_ready), 0);
          check({v.name, ".done_hold"}, 32'(bus.core_hold), 32'(v.exp_hold));
        end
      end
      bus.ld_valid = 1'b0;
      tick();
      exp_hold = '0;
      check({v.name, ".done_end"}, 32'(bus.ld_done), 0);
    end
    check({v.name, ".busy_end"}, 32'(bus.ld_busy), 0);
    check({v.name, ".hold_end"}, 32'(bus.core_hold), 0);
  endtask

  task automatic rd_all(input logic [8:0] a);
    for (int i = 0; i < N; i++) rd_addr_tb[i] = a;
  endtask

  load_vec_t vecs [5];
  logic [8:0] c2_addr [4];

  initial begin : main
    vecs[0] = '{"preload", 1'b0, 0, 'h100, 512, 16'h5000, -1, 0, 1'b0, 4'b1111, 1'b0};
    vecs[1] = '{"bcast",   1'b0, 0, 'h010, 3,   16'hA001, 1,  2, 1'b0, 4'b1111, 1'b0};
    vecs[2] = '{"single",  1'b1, 2, 'h1FE, 4,   16'hB000, -1, 0, 1'b0, 4'b0100, 1'b0};
    vecs[3] = '{"len0",    1'b1, 1, 'h050, 0,   16'hEEEE, -1, 0, 1'b0, 4'b0010, 1'b0};
    vecs[4] = '{"poke",    1'b0, 0, 'h020, 4,   16'hC100, 2,  1, 1'b1, 4'b1111, 1'b0};
    c2_addr[0] = 9'h1FE; c2_addr[1] = 9'h1FF; c2_addr[2] = 9'h000; c2_addr[3] = 9'h001;

    for (int c = 0; c < N; c++)
      for (int a = 0; a < DEPTH; a++) model[c][a] = 'x;
    rst = 1'b1;
    exp_hold = '0;
    rd_mask_tb = 4'b1111;
    rd_rand = '0;
    rd_all(9'd0);
    bus.ld_start = 0; bus.ld_mode = 0; bus.ld_core = 0; bus.ld_base = 0;
    bus.ld_len = 0; bus.ld_valid = 0; bus.ld_data = 0;
    bus.rd_en = '0; bus.rd_addr = '0;
    bus3.ld_start = 0; bus3.ld_mode = 0; bus3.ld_core = 0; bus3.ld_base = 0;
    bus3.ld_len = 0; bus3.ld_valid = 0; bus3.ld_data = 0;
    bus3.rd_en = '0; bus3.rd_addr = '0;

    // Reset for two cycles with reads requested.
    tick();
    check("rst.ld_busy", 32'(bus.ld_busy), 0);
    check("rst.ld_ready", 32'(bus.ld_ready), 0);
    check("rst.ld_done", 32'(bus.ld_done), 0);
    check("rst.ld_err", 32'(bus.ld_err), 0);
    check("rst.core_hold", 32'(bus.core_hold), 0);
    check("rst.rd_data", 32'(bus.rd_data), 0);
    tick();
    check("rst.rd_valid", 32'(bus.rd_valid), 0);
    check("rst3.ld_busy", 32'(bus3.ld_busy), 0);
    rst = 1'b0;
    tick();
    tick();
    check("post_rst.rd_valid", 32'(bus.rd_valid), 32'hF);

    // Table of loads with random reads on every core.
    rd_rand = 4'b1111;
    for (int t = 0; t < 5; t++) run_load(vecs[t]);

    // Directed reads of the loaded contents.
    rd_rand = '0;
    rd_all(9'h010);
    tick();
    for (int c = 0; c < N; c++) check($sformatf("bcast.rd0[%0d]", c), 32'(bus.rd_data[c]), 32'hA001);
    rd_all(9'h012);
    tick();
    for (int c = 0; c < N; c++) check($sformatf("bcast.rd2[%0d]", c), 32'(bus.rd_data[c]), 32'hA003);
    for (int k = 0; k < 4; k++) begin
      rd_all(9'h1FE);
      rd_addr_tb[2] = c2_addr[k];
      tick();
      check($sformatf("single.core2[%0d]", k), 32'(bus.rd_data[2]), 32'(16'hB000 + k));
      check($sformatf("single.core0[%0d]", k), 32'(bus.rd_data[0]), 32'h50FE);
      check($sformatf("single.core3[%0d]", k), 32'(bus.rd_data[3]), 32'h50FE);
    end
    rd_all(9'h023);
    tick();
    for (int c = 0; c < N; c++) check($sformatf("poke.rd[%0d]", c), 32'(bus.rd_data[c]), 32'hC103);

    // Reset after 2 of 5 beats, with a coincident ld_start.
    rd_rand = 4'b1111;
    bus.ld_mode = 1'b1; bus.ld_core = 2'd1; bus.ld_base = 9'h080; bus.ld_len = 10'd5;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    exp_hold = 4'b0010;
    check("midrst.hold", 32'(bus.core_hold), 32'h2);
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'(16'hC000 + i);
      model[1][9'h080 + i] = 16'(16'hC000 + i);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_start = 1'b1;
    rst = 1'b1;
    tick();
    exp_hold = '0;
    check("midrst.busy", 32'(bus.ld_busy), 0);
    check("midrst.hold0", 32'(bus.core_hold), 0);
    check("midrst.done", 32'(bus.ld_done), 0);
    check("midrst.ready", 32'(bus.ld_ready), 0);
    rst = 1'b0;
    bus.ld_start = 1'b0;
    tick();
    check("midrst.busy2", 32'(bus.ld_busy), 0);
    check("midrst.done2", 32'(bus.ld_done), 0);
    rd_rand = '0;
    rd_mask_tb = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      rd_addr_tb[1] = 9'(9'h080 + k);
      tick();
      if (k < 2) check($sformatf("midrst.kept[%0d]", k), 32'(bus.rd_data[1]), 32'(16'hC000 + k));
      else       check($sformatf("midrst.old[%0d]", k), 32'(bus.rd_data[1]), 32'(16'h5180 + k));
    end

    // 3-core instance: invalid target core consumes beats but writes nothing.
    bus3.ld_mode = 1'b0; bus3.ld_base = 9'd0; bus3.ld_len = 10'd2; bus3.ld_start = 1'b1;
    tick();
    bus3.ld_start = 1'b0;
    bus3.ld_valid = 1'b1; bus3.ld_data = 16'h1111;
    tick();
    bus3.ld_data = 16'h2222;
    tick();
    bus3.ld_valid = 1'b0;
    check("n3.pre_done", 32'(bus3.ld_done), 1);
    check("n3.pre_err", 32'(bus3.ld_err), 0);
    tick();
    bus3.ld_mode = 1'b1; bus3.ld_core = 2'd3; bus3.ld_start = 1'b1;
    tick();
    bus3.ld_start = 1'b0;
    check("n3.err_hold", 32'(bus3.core_hold), 0);
    check("n3.err_busy", 32'(bus3.ld_busy), 1);
    check("n3.err_ready", 32'(bus3.ld_ready), 1);
    bus3.ld_valid = 1'b1; bus3.ld_data = 16'hDEAD;
    tick();
    check("n3.err_ready2", 32'(bus3.ld_ready), 1);
    check("n3.err_mid_done", 32'(bus3.ld_done), 0);
    bus3.ld_data = 16'hBEEF;
    tick();
    bus3.ld_valid = 1'b0;
    check("n3.err_done", 32'(bus3.ld_done), 1);
    check("n3.err_err", 32'(bus3.ld_err), 1);
    check("n3.err_hold2", 32'(bus3.core_hold), 0);
    tick();
    check("n3.err_end", 32'(bus3.ld_err), 0);
    check("n3.busy_end", 32'(bus3.ld_busy), 0);
    bus3.rd_en = 3'b111;
    for (int c = 0; c < 3; c++) bus3.rd_addr[c] = 9'd0;
    tick();
    for (int c = 0; c < 3; c++) check($sformatf("n3.rd0[%0d]", c), 32'(bus3.rd_data[c]), 32'h1111);
    for (int c = 0; c < 3; c++) bus3.rd_addr[c] = 9'd1;
    tick();
    for (int c = 0; c < 3; c++) check($sformatf("n3.rd1[%0d]", c), 32'(bus3.rd_data[c]), 32'h2222);
    bus3.rd_en = '0;

    rd_mask_tb = '0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
